// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - samples a multiplexed seven-segment bus and decodes it back to a hex frame
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   sel_q, sel_p;
  logic [CW-1:0]           cnt, cnt_n;
  logic [NUM_DIGITS-1:0]   mask, mask_n;
  logic [4*NUM_DIGITS-1:0] work, work_n;
  logic [NUM_DIGITS-1:0]   werr, werr_n;
  logic                    legal, same, capture, frame_done;
  logic [3:0]              nib;
  logic                    bad;

  // Returns {illegal, nibble}; segment order is gfedcba.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0111111: decode = 5'h00;
      7'b0000110: decode = 5'h01;
      7'b1011011: decode = 5'h02;
      7'b1001111: decode = 5'h03;
      7'b1100110: decode = 5'h04;
      7'b1101101: decode = 5'h05;
      7'b1111101: decode = 5'h06;
      7'b0000111: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1101111: decode = 5'h09;
      7'b1110111: decode = 5'h0a;
      7'b1111100: decode = 5'h0b;
      7'b0111001: decode = 5'h0c;
      7'b1011110: decode = 5'h0d;
      7'b1111001: decode = 5'h0e;
      7'b1110001: decode = 5'h0f;
      default:    decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    legal = $onehot(sel_q);
    same  = (sel_q == sel_p) && (seg_q == seg_p);
    if (!legal)
      cnt_n = '0;
    else if (!same)
      cnt_n = CW'(1);
    else if (cnt == CMAX)
      cnt_n = cnt;
    else
      cnt_n = cnt + CW'(1);
    // Fire only on the transition into CMAX so a held dwell captures once.
    capture = legal && (cnt_n == CMAX) && !(same && (cnt == CMAX));
    {bad, nib} = decode(seg_q);
    work_n = work;
    werr_n = werr;
    mask_n = mask;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && sel_q[i]) begin
        work_n[4*i +: 4] = nib;
        werr_n[i]        = bad;
        mask_n[i]        = 1'b1;
      end
    end
    frame_done = (mask_n == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      seg_p     <= '0;
      sel_q     <= '0;
      sel_p     <= '0;
      cnt       <= '0;
      mask      <= '0;
      work      <= '0;
      werr      <= '0;
      value     <= '0;
      digit_err <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      seg_q <= seg_in;
      sel_q <= digit_sel;
      seg_p <= seg_q;
      sel_p <= sel_q;
      cnt   <= cnt_n;
      work  <= work_n;
      werr  <= werr_n;
      if (frame_done) begin
        mask <= '0;
        if (!out_valid || out_ready) begin
          value     <= work_n;
          digit_err <= werr_n;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        mask <= mask_n;
        if (out_valid && out_ready)
          out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - vector, corner-case and random checks of seven_segment_capture
module tb_seven_segment_capture;
  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg_in = '0;
  logic [ND-1:0] digit_sel = '0;
  logic          out_ready = 1'b0;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_err;
  logic          out_valid;
  logic          overrun;

  always #5 clk = ~clk;

  seven_segment_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_sel(digit_sel),
    .value(value), .digit_err(digit_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  int total = 0;
  int bad = 0;
  int prints = 0;
  int pulses = 0;
  bit chk_en = 0;
  bit rand_ready = 0;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'b0111111;  1: glyph = 7'b0000110;
      2: glyph = 7'b1011011;  3: glyph = 7'b1001111;
      4: glyph = 7'b1100110;  5: glyph = 7'b1101101;
      6: glyph = 7'b1111101;  7: glyph = 7'b0000111;
      8: glyph = 7'b1111111;  9: glyph = 7'b1101111;
      10: glyph = 7'b1110111; 11: glyph = 7'b1111100;
      12: glyph = 7'b0111001; 13: glyph = 7'b1011110;
      14: glyph = 7'b1111001; default: glyph = 7'b1110001;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (prints < 20) $display("FAIL %s actual=%h required=%h", name, act, exp);
      prints++;
    end
  endtask

  // Reference model: counts the run length of identical legal samples seen one cycle late.
  logic [6:0]    m_seg, m_pseg;
  logic [ND-1:0] m_sel, m_psel;
  int            run;
  logic [3:0]    m_nib [ND];
  logic          m_werr [ND];
  logic          m_got [ND];
  logic [4*ND-1:0] m_value;
  logic [ND-1:0] m_err;
  logic          m_valid, m_overrun;

  always @(posedge clk) begin
    bit ok, all, e;
    int d, nb;
    if (rst) begin
      m_seg = '0; m_pseg = '0; m_sel = '0; m_psel = '0; run = 0;
      for (int i = 0; i < ND; i++) begin m_nib[i] = '0; m_werr[i] = 0; m_got[i] = 0; end
      m_value = '0; m_err = '0; m_valid = 0; m_overrun = 0;
    end else begin
      ok = ($countones(m_sel) == 1);
      if (ok && m_sel == m_psel && m_seg == m_pseg) run++;
      else run = ok ? 1 : 0;
      if (ok && run == SC) begin
        d = 0;
        for (int i = 0; i < ND; i++) if (m_sel[i]) d = i;
        nb = 0; e = 1;
        for (int k = 0; k < 16; k++) if (glyph(k) == m_seg) begin nb = k; e = 0; end
        m_nib[d] = 4'(nb); m_werr[d] = e; m_got[d] = 1;
      end
      all = 1;
      for (int i = 0; i < ND; i++) all = all & m_got[i];
      if (all) begin
        for (int i = 0; i < ND; i++) m_got[i] = 0;
        if (!m_valid || out_ready) begin
          for (int i = 0; i < ND; i++) begin m_value[4*i +: 4] = m_nib[i]; m_err[i] = m_werr[i]; end
          m_valid = 1;
        end else m_overrun = 1;
      end else if (m_valid && out_ready) m_valid = 0;
      m_psel = m_sel; m_pseg = m_seg;
      m_sel = digit_sel; m_seg = seg_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid) pulses++;
      check("model", {10'd0, value, digit_err, out_valid, overrun},
            {10'd0, m_value, m_err, m_valid, m_overrun});
    end
  end

  task automatic hold(input int n);
    repeat (n) begin
      if (rand_ready) out_ready = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    digit_sel = ND'(1 << d);
    seg_in = p;
    hold(n);
  endtask

  task automatic blank(input int n);
    digit_sel = '0;
    hold(n);
  endtask

  task automatic scan(input logic [3:0][6:0] p);
    for (int d = 0; d < ND; d++) show(d, p[d], 5);
  endtask

  typedef struct {
    logic [3:0][6:0] pats;
    logic [15:0]     val;
    logic [3:0]      err;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0].pats = {glyph(1), glyph(2), glyph(3), glyph(4)};
    vecs[0].val = 16'h1234; vecs[0].err = 4'b0000;
    vecs[1].pats = {glyph(10), glyph(11), glyph(12), 7'b0000001};
    vecs[1].val = 16'hABC0; vecs[1].err = 4'b0001;
    vecs[2].pats = {glyph(8), glyph(8), glyph(8), glyph(8)};
    vecs[2].val = 16'h8888; vecs[2].err = 4'b0000;
    vecs[3].pats = {glyph(12), glyph(13), glyph(14), glyph(15)};
    vecs[3].val = 16'hCDEF; vecs[3].err = 4'b0000;
    vecs[4].pats = {glyph(6), glyph(9), 7'b1000000, glyph(0)};
    vecs[4].val = 16'h6900; vecs[4].err = 4'b0010;

    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    blank(2);

    for (int v = 0; v < 5; v++) begin
      pulses = 0;
      scan(vecs[v].pats);
      blank(4);
      check($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].val));
      check($sformatf("vec%0d_err", v), 32'(digit_err), 32'(vecs[v].err));
      check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd1);
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
    end

    pulses = 0;
    show(0, glyph(5), 5); show(1, glyph(6), 5); show(2, glyph(7), 3); show(3, glyph(8), 5);
    blank(4);
    check("short_dwell_pulses", 32'(pulses), 32'd0);
    show(2, glyph(7), SC);
    blank(4);
    check("redwell_pulses", 32'(pulses), 32'd1);
    check("redwell_value", 32'(value), 32'h8765);

    out_ready = 1'b0;
    scan({glyph(1), glyph(1), glyph(1), glyph(1)});
    blank(4);
    scan({glyph(2), glyph(2), glyph(2), glyph(2)});
    blank(4);
    check("ovr_value", 32'(value), 32'h1111);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    hold(1);
    out_ready = 1'b0;
    check("ovr_valid_fall", 32'(out_valid), 32'd0);
    blank(2);

    out_ready = 1'b1;
    pulses = 0;
    digit_sel = 4'b0011; seg_in = glyph(1); hold(10);
    blank(10);
    show(1, glyph(2), 5); show(2, glyph(2), 5); show(3, glyph(2), 5);
    blank(4);
    check("blank_pulses", 32'(pulses), 32'd0);
    show(0, glyph(2), 5);
    blank(4);
    check("blank_value", 32'(value), 32'h2222);
    check("blank_done_pulses", 32'(pulses), 32'd1);

    show(0, glyph(9), 5); show(1, glyph(9), 5); show(2, glyph(9), 5);
    rst = 1'b1;
    hold(1);
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_err", 32'(digit_err), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    pulses = 0;
    show(3, glyph(3), 5);
    blank(4);
    check("midrst_partial", 32'(pulses), 32'd0);
    show(0, glyph(3), 5); show(1, glyph(3), 5); show(2, glyph(3), 5);
    blank(4);
    check("midrst_value2", 32'(value), 32'h3333);
    check("midrst_pulses", 32'(pulses), 32'd1);

    pulses = 0;
    show(0, glyph(0), 5); show(1, glyph(1), 2); show(1, glyph(7), 4);
    show(2, glyph(0), 5); show(3, glyph(0), 5);
    blank(4);
    check("overwrite_value", 32'(value), 32'h0070);
    check("overwrite_pulses", 32'(pulses), 32'd1);

    rand_ready = 1;
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        rst = 1'b1; hold(1); rst = 1'b0;
      end else begin
        if (r < 4) digit_sel = ND'($urandom);
        else digit_sel = ND'(1 << $urandom_range(0, ND - 1));
        if (r < 8) seg_in = 7'($urandom);
        else seg_in = glyph($urandom_range(0, 15));
        hold($urandom_range(1, 7));
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    blank(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
